// File: rtl/primus_operand_fetch_if.sv
// Bundle of the decode, writeback and ALU-side signals of the operand-fetch stage.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both 1; the producer holds its payload steady until then.
interface primus_operand_fetch_if #(
  parameter int XLEN = 16,
  parameter int AW   = 4
);
  logic            flush_i;
  logic            dec_valid_i;
  logic            dec_ready_o;
  logic [AW-1:0]   dec_rs1_i;
  logic [AW-1:0]   dec_rs2_i;
  logic            dec_use_imm_i;
  logic [XLEN-1:0] dec_imm_i;
  logic [3:0]      dec_op_i;
  logic [AW-1:0]   dec_rd_i;
  logic            wb_en_i;
  logic [AW-1:0]   wb_rd_i;
  logic [XLEN-1:0] wb_data_i;
  logic            alu_valid_o;
  logic            alu_ready_i;
  logic [XLEN-1:0] rs1_data_q_o;
  logic [XLEN-1:0] rs2_data_q_o;
  logic [3:0]      alu_op_o;
  logic [AW-1:0]   alu_rd_o;

  modport master (
    output flush_i, dec_valid_i, dec_rs1_i, dec_rs2_i, dec_use_imm_i, dec_imm_i,
           dec_op_i, dec_rd_i, wb_en_i, wb_rd_i, wb_data_i, alu_ready_i,
    input  dec_ready_o, alu_valid_o, rs1_data_q_o, rs2_data_q_o, alu_op_o, alu_rd_o
  );

  modport slave (
    input  flush_i, dec_valid_i, dec_rs1_i, dec_rs2_i, dec_use_imm_i, dec_imm_i,
           dec_op_i, dec_rd_i, wb_en_i, wb_rd_i, wb_data_i, alu_ready_i,
    output dec_ready_o, alu_valid_o, rs1_data_q_o, rs2_data_q_o, alu_op_o, alu_rd_o
  );
endinterface

// File: rtl/primus_operand_fetch.sv
// Operand-fetch stage: register file, writeback bypass and a 2-entry operand queue
// whose entries keep snooping writebacks until the ALU takes them.
module primus_operand_fetch #(
  parameter int XLEN  = 16,
  parameter int NREGS = 16
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  primus_operand_fetch_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      op;
    logic [AW-1:0]   rd;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            b_imm;
  } entry_t;

  logic [XLEN-1:0] rf [NREGS];
  entry_t          q0, q1;
  logic [1:0]      count;

  logic            wb_hit;
  logic            push, pop;
  logic [XLEN-1:0] rs1_val, rs2_val;
  entry_t          new_entry, s0, s1;

  // Entries track their source tags so a later writeback can refresh them in place.
  function automatic entry_t snoop(input entry_t e, input logic hit,
                                   input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
    entry_t r;
    r = e;
    if (hit && (e.rs1 == rd)) r.a = data;
    if (hit && !e.b_imm && (e.rs2 == rd)) r.b = data;
    return r;
  endfunction

  assign wb_hit = bus.wb_en_i && (bus.wb_rd_i != '0);

  always_comb begin
    rs1_val = '0;
    if (bus.dec_rs1_i != '0)
      rs1_val = (wb_hit && (bus.wb_rd_i == bus.dec_rs1_i)) ? bus.wb_data_i : rf[bus.dec_rs1_i];
  end

  always_comb begin
    rs2_val = '0;
    if (bus.dec_rs2_i != '0)
      rs2_val = (wb_hit && (bus.wb_rd_i == bus.dec_rs2_i)) ? bus.wb_data_i : rf[bus.dec_rs2_i];
  end

  always_comb begin
    new_entry       = '0;
    new_entry.a     = rs1_val;
    new_entry.b     = bus.dec_use_imm_i ? bus.dec_imm_i : rs2_val;
    new_entry.op    = bus.dec_op_i;
    new_entry.rd    = bus.dec_rd_i;
    new_entry.rs1   = bus.dec_rs1_i;
    new_entry.rs2   = bus.dec_rs2_i;
    new_entry.b_imm = bus.dec_use_imm_i;
  end

  assign s0 = snoop(q0, wb_hit, bus.wb_rd_i, bus.wb_data_i);
  assign s1 = snoop(q1, wb_hit, bus.wb_rd_i, bus.wb_data_i);

  assign bus.dec_ready_o = (count != 2'd2) && !bus.flush_i;
  assign bus.alu_valid_o = (count != 2'd0);
  assign push            = bus.dec_valid_i && bus.dec_ready_o;
  assign pop             = bus.alu_valid_o && bus.alu_ready_i;

  // q0 is always the head; a pop at count 2 shifts the snooped tail forward.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= 2'd0;
      q0    <= '0;
      q1    <= '0;
    end else if (bus.flush_i) begin
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            q0    <= new_entry;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            q0 <= new_entry;
          end else if (pop) begin
            count <= 2'd0;
          end else if (push) begin
            q0    <= s0;
            q1    <= new_entry;
            count <= 2'd2;
          end else begin
            q0 <= s0;
          end
        end
        default: begin
          if (pop) begin
            q0    <= s1;
            count <= 2'd1;
          end else begin
            q0 <= s0;
            q1 <= s1;
          end
        end
      endcase
    end
  end

  // x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_hit) begin
      rf[bus.wb_rd_i] <= bus.wb_data_i;
    end
  end

  assign bus.rs1_data_q_o = bus.alu_valid_o ? q0.a  : '0;
  assign bus.rs2_data_q_o = bus.alu_valid_o ? q0.b  : '0;
  assign bus.alu_op_o     = bus.alu_valid_o ? q0.op : '0;
  assign bus.alu_rd_o     = bus.alu_valid_o ? q0.rd : '0;

endmodule
